mcu_mem_ctrl: RTL
=================

// Module: mcu_mem_ctrl
// PURPOSE
//  Memory-side controller that sits directly upstream of the 2048x16 single-port MCU RAM and owns all of its control pins.
//  Arbitrates the core's data load/store port against a sequential instruction prefetcher.
//  Returns read data to the correct requester, accounting for the RAM's 1-cycle read latency (bypass read mode).
//  Buffers prefetched instructions in a small FIFO and supports branch redirect with flush.
// PARAMETERS
//  RESET_PC    11'h000  fetch address loaded on reset
//  FIFO_DEPTH  2        prefetch entries; must be a power of two, >=2
//  WP_LIMIT    11'h040  write-protect boundary: addresses < WP_LIMIT are protected; used only with MCU_MEM_WP_EN
// PORTS
//  clk           in   1   system clock; all state updates on its rising edge
//  reset         in   1   synchronous, active-high reset
//  d_valid       in   1   data request valid
//  d_we          in   1   1 = store, 0 = load
//  d_addr        in   11  data word address
//  d_wdata       in   16  store data
//  d_ready       out  1   data request accepted this cycle
//  d_rvalid      out  1   load data valid (pulse)
//  d_rdata       out  16  load data
//  d_wp_err      out  1   protected-write pulse (0 when the macro is absent)
//  redirect      in   1   flush prefetch and restart at target
//  redirect_pc   in   11  new fetch address
//  instr_valid   out  1   FIFO head valid
//  instr_data    out  16  FIFO head instruction
//  instr_addr    out  11  FIFO head address
//  instr_ready   in   1   consumer pops head when instr_valid && instr_ready
//  ram_ce        out  1   RAM clock enable (access strobe)
//  ram_oce       out  1   RAM output clock enable; tied 1
//  ram_wre       out  1   RAM write enable
//  ram_ad        out  11  RAM word address
//  ram_din       out  16  RAM write data
//  ram_dout      in   16  RAM read data, valid the cycle after a read strobe
// BEHAVIOUR
//  - Reset values: d_rvalid, d_wp_err, instr_valid = 0. FIFO empty. No read in flight. fetch_pc = RESET_PC.
//    ram_ce = ram_wre = 0. d_ready = 0 while reset is asserted.
//  - RAM ports: ram_ce, ram_wre, ram_ad and ram_din are combinational from the arbitration decision.
//    One access per cycle.
//  - Arbitration: data has fixed priority. d_ready = !reset, so every data request is accepted in the cycle it is presented.
//  - Load: issued in cycle N. d_rvalid = 1 and d_rdata = ram_dout in cycle N+1.
//  - Store: ram_wre = 1 in cycle N. No response pulse.
//  - Fetch issue: a fetch is issued when there is no data request and (FIFO count + fetch in flight) < FIFO_DEPTH.
//    ram_ad = fetch_pc. fetch_pc increments by 1 per issued fetch and wraps from 11'h7FF to 11'h000.
//  - Fetch return: the word returns in cycle N+1 and is pushed with its address, unless a redirect has marked it stale.
//  - FIFO: push and pop in the same cycle are both legal; count is unchanged. Pop when empty has no effect.
//    Overflow is impossible by the issue rule.
//  - Redirect (1-cycle pulse): FIFO is flushed, fetch_pc = redirect_pc, and any in-flight fetch is discarded.
//    A fetch from redirect_pc may issue in the same cycle as the redirect if the port is free.
//    Redirect wins over a simultaneous pop and over a simultaneous push.
//  - Simultaneous data request and redirect: the data access wins the RAM port.
//    The target fetch issues in the first free cycle.
//  - Reset mid-operation: any in-flight response is dropped, with no d_rvalid pulse and no push.
// CONFIGURATION
//  MCU_MEM_WP_EN defined:
//   - A store with d_addr < WP_LIMIT is suppressed: ram_ce = ram_wre = 0 that cycle.
//   - The store is still accepted (d_ready = 1).
//   - d_wp_err pulses 1 in the cycle after the suppressed store.
//   - A fetch may use the freed port in that cycle.
//  MCU_MEM_WP_EN undefined: all stores reach the RAM. d_wp_err is tied 0. WP_LIMIT is unused.
// STRUCTURE
//  - Package mcu_mem_pkg: ADDR_W = 11, DATA_W = 16, RAM_WORDS = 2048, and the typedef fetch_entry_t {addr, data}.
//  - Sub-module mcu_fetch_fifo: parameterised FIFO_DEPTH x fetch_entry_t with push, pop, flush, count, and head outputs.
//  - The top level holds the arbiter, fetch_pc, in-flight tag {valid, is_data, stale}, and the write-protect logic.
// TESTING
//  1. Reset, then no data traffic -> fetches to 0x000 and 0x001 in consecutive cycles.
//     instr_valid rises 2 cycles after reset deasserts. Fetching stalls with 2 entries when instr_ready = 0.
//  2. Store 0xBEEF to 0x100, then load 0x100 in the next cycle -> d_rvalid = 1 one cycle after the load, d_rdata = 0xBEEF.
//     No fetch issues in either cycle.
//  3. Redirect to 0x7FE while a fetch is in flight -> the stale word is never visible.
//     instr_addr sequence is 0x7FE, 0x7FF, 0x000 (wrap).
//  4. Redirect, pop and data load in the same cycle -> FIFO empty next cycle and the load returns correctly.
//     First fetch is from the target, issued the cycle after.
//  5. With MCU_MEM_WP_EN and WP_LIMIT = 0x040: store to 0x03F -> ram_wre stays 0 and d_wp_err pulses once.
//     A subsequent load of 0x03F returns the original contents. A store to 0x040 succeeds.
//  6. Assert reset one cycle after a load issues -> no d_rvalid pulse. fetch_pc = RESET_PC.

Source files
------------

// File: rtl/mcu_mem_pkg.sv
// Shared widths and the prefetch FIFO entry type for the MCU memory controller.
package mcu_mem_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RAM_WORDS = 2048;

  // One prefetched instruction word tagged with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/mcu_fetch_fifo.sv
// Small prefetch FIFO of fetch_entry_t; flush wins over push and pop.
module mcu_fetch_fifo
  import mcu_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  fetch_entry_t                  push_entry,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output fetch_entry_t                  head,
  output logic                          head_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  // Popping an empty FIFO is ignored.
  always_comb begin
    do_pop     = pop && (count != '0);
    head       = mem[rd_ptr];
    head_valid = (count != '0);
  end

  // Pointer and occupancy tracking; the issue rule upstream prevents overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/mcu_mem_ctrl.sv
// Memory-side controller for the 2048x16 MCU RAM: data port has fixed priority
// over a sequential instruction prefetcher feeding a small FIFO.
// Optional feature macro: MCU_MEM_WP_EN (suppress stores below WP_LIMIT, pulse d_wp_err).
module mcu_mem_ctrl
  import mcu_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 11'h000,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] WP_LIMIT   = 11'h040
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wp_err,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

`ifdef MCU_MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              tag_valid;
  logic              tag_is_data;
  logic [ADDR_W-1:0] tag_addr;
  logic              resp_stale;
  logic              data_req;
  logic              wp_block;
  logic              data_port;
  logic              load_issue;
  logic              fetch_inflight;
  logic [OCC_W-1:0]  occ;
  logic              space_ok;
  logic              fetch_issue;
  logic              fifo_push;
  fetch_entry_t      push_entry;
  fetch_entry_t      fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  // Arbitration: data wins the port, a fetch takes it only when free and the FIFO has room.
  always_comb begin
    data_req       = d_valid && !reset;
    wp_block       = WP_ON && data_req && d_we && (d_addr < WP_LIMIT);
    data_port      = data_req && !wp_block;
    load_issue     = data_port && !d_we;
    fetch_addr     = redirect ? redirect_pc : fetch_pc;
    fetch_inflight = tag_valid && !tag_is_data;
    occ            = OCC_W'(fifo_count) + OCC_W'(fetch_inflight);
    // A redirect empties both the FIFO and the in-flight slot this cycle.
    space_ok       = redirect || (occ < OCC_W'(FIFO_DEPTH));
    fetch_issue    = !reset && !data_port && space_ok;
  end

  // RAM pins driven straight from the arbitration decision.
  always_comb begin
    ram_ce  = data_port || fetch_issue;
    ram_oce = 1'b1;
    ram_wre = data_port && d_we;
    ram_ad  = data_port ? d_addr : fetch_addr;
    ram_din = d_wdata;
    d_ready = !reset;
  end

  // Response steering: a redirect in the return cycle makes a returning fetch stale.
  always_comb begin
    resp_stale      = redirect;
    d_rvalid        = tag_valid && tag_is_data && !reset;
    d_rdata         = ram_dout;
    fifo_push       = tag_valid && !tag_is_data && !reset && !resp_stale;
    push_entry      = '0;
    push_entry.addr = tag_addr;
    push_entry.data = ram_dout;
  end

  // In-flight tag, fetch pointer and write-protect error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      tag_valid   <= 1'b0;
      tag_is_data <= 1'b0;
      tag_addr    <= '0;
      d_wp_err    <= 1'b0;
    end else begin
      tag_valid   <= load_issue || fetch_issue;
      tag_is_data <= load_issue;
      tag_addr    <= fetch_addr;
      d_wp_err    <= wp_block;
      if (fetch_issue) begin
        fetch_pc <= fetch_addr + 1'b1;
      end else if (redirect) begin
        fetch_pc <= redirect_pc;
      end
    end
  end

  mcu_fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (instr_ready),
    .flush      (redirect),
    .count      (fifo_count),
    .head       (fifo_head),
    .head_valid (instr_valid)
  );

  // FIFO head presented to the instruction consumer.
  always_comb begin
    instr_data = fifo_head.data;
    instr_addr = fifo_head.addr;
  end

endmodule
